// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared types and helpers for the configurable UART blocks.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP       = 3'd4,
    ST_BREAK_WAIT = 3'd5
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int calc_tick_div(input int clk_frq, input int baud, input int os);
    return clk_frq / (baud * os);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module : uart_baud_tick
// Brief  : Oversample tick generator; restart re-phases it to an external edge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FRQ    = 250000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic areset,
  input  logic restart,
  output logic tick
);

  localparam int c_DIV = calc_tick_div(CLK_FRQ, BAUD_RATE, OVERSAMPLE);
  localparam int c_CW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam logic [c_CW-1:0] c_TOP = c_CW'(c_DIV - 1);

  if (c_DIV < 1) begin : g_bad_div
    $error("uart_baud_tick: clock too slow for BAUD_RATE*OVERSAMPLE");
  end

  logic [c_CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (areset || restart) begin
      r_cnt <= '0;
    end else if (r_cnt == c_TOP) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_TOP) && !restart;

endmodule

`default_nettype wire

// File: rtl/uart_rx_cfg.sv
// ============================================================================
// Module : uart_rx_cfg
// Brief  : Configurable UART receiver with majority voting, error flags and
//          a valid/ready output holding register with overrun detection.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FRQ    = 250000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 data_in,
  input  logic                 rx_ready,
  output logic                 rx_open,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_saved,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_overrun
);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      calc_tick_div(CLK_FRQ, BAUD_RATE, OVERSAMPLE) < 1) begin : g_bad_cfg
    $error("uart_rx_cfg: illegal parameter set");
  end

  localparam int c_TW = $clog2(OVERSAMPLE);
  localparam int c_BW = $clog2(DATA_BITS);
  localparam logic [c_TW-1:0] c_V0   = c_TW'(OVERSAMPLE/2 - 1);
  localparam logic [c_TW-1:0] c_V1   = c_TW'(OVERSAMPLE/2);
  localparam logic [c_TW-1:0] c_V2   = c_TW'(OVERSAMPLE/2 + 1);
  localparam logic [c_TW-1:0] c_LAST = c_TW'(OVERSAMPLE - 1);
  localparam logic [c_BW-1:0] c_BLAST = c_BW'(DATA_BITS - 1);

  logic [1:0]           r_sync;
  logic                 r_sync_q;
  rx_state_e            r_state;
  logic                 r_open;
  logic [c_TW-1:0]      r_tcnt;
  logic                 r_v0, r_v1;
  logic [c_BW-1:0]      r_bcnt;
  logic                 r_scnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_pe_acc, r_fe_acc, r_any_one, r_brk, r_done;
  logic                 r_valid, r_pe, r_fe, r_break, r_overrun;
  logic [DATA_BITS-1:0] r_saved;

  logic w_sync, w_fall, w_restart, w_tick, w_vote, w_bit;

  assign w_sync    = r_sync[1];
  assign w_fall    = r_sync_q & ~w_sync;
  assign w_restart = (r_state == ST_IDLE) && w_fall;
  assign w_vote    = w_tick && (r_tcnt == c_V2);
  assign w_bit     = (r_v0 & r_v1) | (r_v0 & w_sync) | (r_v1 & w_sync);

  uart_baud_tick #(
    .CLK_FRQ   (CLK_FRQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk    (clk),
    .areset (areset),
    .restart(w_restart),
    .tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (areset) begin
      r_sync   <= 2'b11;
      r_sync_q <= 1'b1;
    end else begin
      r_sync   <= {r_sync[0], data_in};
      r_sync_q <= w_sync;
    end
  end

  // State advances at each bit's vote tick; r_tcnt keeps the bit phase running.
  always_ff @(posedge clk) begin
    if (areset) begin
      r_state   <= ST_IDLE;
      r_open    <= 1'b1;
      r_tcnt    <= '0;
      r_v0      <= 1'b1;
      r_v1      <= 1'b1;
      r_bcnt    <= '0;
      r_scnt    <= 1'b0;
      r_shift   <= '0;
      r_pe_acc  <= 1'b0;
      r_fe_acc  <= 1'b0;
      r_any_one <= 1'b0;
      r_brk     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_tick && (r_state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})) begin
        r_tcnt <= (r_tcnt == c_LAST) ? '0 : r_tcnt + 1'b1;
        if (r_tcnt == c_V0) r_v0 <= w_sync;
        if (r_tcnt == c_V1) r_v1 <= w_sync;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state   <= ST_START;
            r_open    <= 1'b0;
            r_tcnt    <= '0;
            r_bcnt    <= '0;
            r_scnt    <= 1'b0;
            r_pe_acc  <= 1'b0;
            r_fe_acc  <= 1'b0;
            r_any_one <= 1'b0;
          end
        end
        ST_START: begin
          if (w_vote) begin
            if (w_bit == START_BIT) begin
              r_state <= ST_DATA;
            end else begin
              r_state <= ST_IDLE;
              r_open  <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_vote) begin
            r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_any_one <= r_any_one | w_bit;
            if (r_bcnt == c_BLAST) begin
              r_bcnt  <= '0;
              r_state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              r_bcnt <= r_bcnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (w_vote) begin
            r_any_one <= r_any_one | w_bit;
            r_pe_acc  <= (PARITY == int'(PAR_ODD)) ? ~(^r_shift ^ w_bit) : (^r_shift ^ w_bit);
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_vote) begin
            r_any_one <= r_any_one | w_bit;
            if (w_bit != STOP_BIT) r_fe_acc <= 1'b1;
            if (r_scnt == 1'(STOP_BITS - 1)) begin
              r_done <= 1'b1;
              r_brk  <= ~(r_any_one | w_bit);
              if (!(r_any_one | w_bit)) begin
                r_state <= ST_BREAK_WAIT;
                r_tcnt  <= '0;
              end else begin
                r_state <= ST_IDLE;
                r_open  <= 1'b1;
              end
            end else begin
              r_scnt <= 1'b1;
            end
          end
        end
        ST_BREAK_WAIT: begin
          // Line must stay high for a whole bit before re-arming.
          if (!w_sync) begin
            r_tcnt <= '0;
          end else if (w_tick) begin
            if (r_tcnt == c_LAST) begin
              r_tcnt  <= '0;
              r_state <= ST_IDLE;
              r_open  <= 1'b1;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_open  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      r_valid   <= 1'b0;
      r_saved   <= '0;
      r_pe      <= 1'b0;
      r_fe      <= 1'b0;
      r_break   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_done) begin
        if (!r_valid || rx_ready) begin
          r_valid <= 1'b1;
          r_saved <= r_brk ? '0 : r_shift;
          r_pe    <= r_brk ? 1'b0 : r_pe_acc;
          r_fe    <= r_fe_acc | r_brk;
          r_break <= r_brk;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_open       = r_open;
  assign rx_valid      = r_valid;
  assign rx_saved      = r_saved;
  assign rx_parity_err = r_pe;
  assign rx_frame_err  = r_fe;
  assign rx_break      = r_break;
  assign rx_overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
// ============================================================================
// Module : tb_uart_rx_cfg
// Brief  : Directed bench for uart_rx_cfg in 8N1, 7E1 and 8N2 configurations.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_cfg;

  localparam int c_BIT = 160;

  logic       clk = 1'b0;
  logic       areset;
  logic [2:0] line, rdy;
  logic [2:0] opn, vld, pe, fe, brk, ovr;
  logic [7:0] sv0, sv2;
  logic [6:0] sv1;
  logic [8:0] sv [3];

  int         checks = 0;
  int         failures = 0;
  int         acc_cnt [3] = '{0, 0, 0};
  int         ovr_cnt [3] = '{0, 0, 0};
  logic [8:0] acc_data [3];
  logic       acc_pe [3], acc_fe [3], acc_brk [3];

  always #5 clk = ~clk;

  assign sv[0] = {1'b0, sv0};
  assign sv[1] = {2'b00, sv1};
  assign sv[2] = {1'b0, sv2};

  uart_rx_cfg #(.CLK_FRQ(18432000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .OVERSAMPLE(16)) u_8n1 (
    .clk(clk), .areset(areset), .data_in(line[0]), .rx_ready(rdy[0]),
    .rx_open(opn[0]), .rx_valid(vld[0]), .rx_saved(sv0), .rx_parity_err(pe[0]),
    .rx_frame_err(fe[0]), .rx_break(brk[0]), .rx_overrun(ovr[0]));

  uart_rx_cfg #(.CLK_FRQ(18432000), .BAUD_RATE(115200), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(1), .OVERSAMPLE(16)) u_7e1 (
    .clk(clk), .areset(areset), .data_in(line[1]), .rx_ready(rdy[1]),
    .rx_open(opn[1]), .rx_valid(vld[1]), .rx_saved(sv1), .rx_parity_err(pe[1]),
    .rx_frame_err(fe[1]), .rx_break(brk[1]), .rx_overrun(ovr[1]));

  uart_rx_cfg #(.CLK_FRQ(18432000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(2), .OVERSAMPLE(16)) u_8n2 (
    .clk(clk), .areset(areset), .data_in(line[2]), .rx_ready(rdy[2]),
    .rx_open(opn[2]), .rx_valid(vld[2]), .rx_saved(sv2), .rx_parity_err(pe[2]),
    .rx_frame_err(fe[2]), .rx_break(brk[2]), .rx_overrun(ovr[2]));

  // Record every accepted word and every overrun cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (vld[k] && rdy[k]) begin
        acc_cnt[k]++;
        acc_data[k] = sv[k];
        acc_pe[k]   = pe[k];
        acc_fe[k]   = fe[k];
        acc_brk[k]  = brk[k];
      end
      if (ovr[k]) ovr_cnt[k]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives n bits of pat onto line w, LSB first, then returns the line to idle.
  task automatic send(input int w, input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      line[w] = pat[i];
      wait_cyc(c_BIT);
    end
    line[w] = 1'b1;
  endtask

  initial begin
    areset = 1'b1;
    line   = 3'b111;
    rdy    = 3'b111;
    wait_cyc(3);
    areset = 1'b0;
    wait_cyc(1);
    chk("reset_open",  32'(opn[0]), 32'd1);
    chk("reset_valid", 32'(vld[0]), 32'd0);
    chk("reset_saved", 32'(sv0),    32'h00);
    chk("reset_flags", 32'({pe[0], fe[0], brk[0], ovr[0]}), 32'd0);

    // 8N1 back-to-back frames
    send(0, {6'h3F, 1'b1, 8'hA5, 1'b0}, 10);
    chk("t1_cnt",   32'(acc_cnt[0]), 32'd1);
    chk("t1_data",  32'(acc_data[0]), 32'hA5);
    chk("t1_flags", 32'({acc_pe[0], acc_fe[0], acc_brk[0]}), 32'd0);
    chk("t1_open",  32'(opn[0]), 32'd1);
    send(0, {6'h3F, 1'b1, 8'h00, 1'b0}, 10);
    chk("t1b_cnt",   32'(acc_cnt[0]), 32'd2);
    chk("t1b_data",  32'(acc_data[0]), 32'h00);
    chk("t1b_flags", 32'({acc_pe[0], acc_fe[0], acc_brk[0]}), 32'd0);
    wait_cyc(20);

    // 7E1 parity good then bad
    send(1, {6'h3F, 1'b1, 1'b0, 7'h03, 1'b0}, 10);
    chk("t2a_cnt",  32'(acc_cnt[1]), 32'd1);
    chk("t2a_data", 32'(acc_data[1]), 32'h03);
    chk("t2a_pe",   32'(acc_pe[1]), 32'd0);
    wait_cyc(20);
    send(1, {6'h3F, 1'b1, 1'b1, 7'h03, 1'b0}, 10);
    chk("t2b_cnt",  32'(acc_cnt[1]), 32'd2);
    chk("t2b_data", 32'(acc_data[1]), 32'h03);
    chk("t2b_pe",   32'(acc_pe[1]), 32'd1);
    chk("t2b_fe",   32'(acc_fe[1]), 32'd0);
    wait_cyc(20);

    // 8N2 clean frame, then second stop bit low
    send(2, {5'h1F, 1'b1, 1'b1, 8'h55, 1'b0}, 11);
    chk("t3a_cnt", 32'(acc_cnt[2]), 32'd1);
    chk("t3a_fe",  32'(acc_fe[2]), 32'd0);
    wait_cyc(20);
    send(2, {5'h1F, 1'b0, 1'b1, 8'h55, 1'b0}, 11);
    chk("t3b_cnt",  32'(acc_cnt[2]), 32'd2);
    chk("t3b_data", 32'(acc_data[2]), 32'h55);
    chk("t3b_fe",   32'(acc_fe[2]), 32'd1);
    chk("t3b_brk",  32'(acc_brk[2]), 32'd0);
    wait_cyc(20);

    // Break: 12 bit times low
    line[0] = 1'b0;
    wait_cyc(12 * c_BIT);
    line[0] = 1'b1;
    wait_cyc(2 * c_BIT);
    chk("t4_cnt",  32'(acc_cnt[0]), 32'd3);
    chk("t4_brk",  32'(acc_brk[0]), 32'd1);
    chk("t4_fe",   32'(acc_fe[0]), 32'd1);
    chk("t4_data", 32'(acc_data[0]), 32'h00);
    send(0, {6'h3F, 1'b1, 8'h3C, 1'b0}, 10);
    chk("t4b_cnt",   32'(acc_cnt[0]), 32'd4);
    chk("t4b_data",  32'(acc_data[0]), 32'h3C);
    chk("t4b_flags", 32'({acc_fe[0], acc_brk[0]}), 32'd0);
    wait_cyc(20);

    // Short glitch is a false start
    line[0] = 1'b0;
    wait_cyc(30);
    line[0] = 1'b1;
    wait_cyc(10);
    chk("t5_open_low", 32'(opn[0]), 32'd0);
    wait_cyc(150);
    chk("t5_open_back", 32'(opn[0]), 32'd1);
    chk("t5_cnt",       32'(acc_cnt[0]), 32'd4);

    // Reset pulse during the stop bit of 0x7E, ahead of its vote
    fork
      send(0, {6'h3F, 1'b1, 8'h7E, 1'b0}, 10);
      begin
        wait_cyc(1480);
        areset = 1'b1;
        wait_cyc(1);
        areset = 1'b0;
      end
    join
    wait_cyc(20);
    chk("t5r_cnt",   32'(acc_cnt[0]), 32'd4);
    chk("t5r_valid", 32'(vld[0]), 32'd0);
    chk("t5r_saved", 32'(sv0), 32'h00);
    chk("t5r_flags", 32'({pe[0], fe[0], brk[0], ovr[0]}), 32'd0);
    chk("t5r_open",  32'(opn[0]), 32'd1);

    // Overrun with consumer stalled
    rdy[0] = 1'b0;
    send(0, {6'h3F, 1'b1, 8'h11, 1'b0}, 10);
    chk("t6_valid", 32'(vld[0]), 32'd1);
    chk("t6_saved", 32'(sv0), 32'h11);
    chk("t6_ovr0",  32'(ovr_cnt[0]), 32'd0);
    send(0, {6'h3F, 1'b1, 8'h22, 1'b0}, 10);
    chk("t6_ovr1",  32'(ovr_cnt[0]), 32'd1);
    chk("t6_hold",  32'(sv0), 32'h11);
    chk("t6_valid2", 32'(vld[0]), 32'd1);
    rdy[0] = 1'b1;
    wait_cyc(1);
    chk("t6_vfall", 32'(vld[0]), 32'd0);
    chk("t6_acc",   32'(acc_data[0]), 32'h11);
    chk("t6_cnt",   32'(acc_cnt[0]), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
